uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 8680, meaning max clocks between consecutive frame bytes (20 bit times at CLKS_PER_BIT=434).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning frame start marker.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rx_rd  in  1  one-cycle strobe: rx_data holds a valid received byte.
REQ-006 rx_data  in  8  received byte; sampled only when rx_rd=1.
REQ-007 reg_wr  out  1  register write request; held until reg_ack.
REQ-008 reg_addr  out  7  register address; stable while reg_wr=1.
REQ-009 reg_wdata  out  16  register write data; stable while reg_wr=1.
REQ-010 reg_ack  in  1  register bank accepts the write when reg_wr=1 and reg_ack=1 on the same edge.
REQ-011 busy  out  1  high in any state other than S_SYNC.
REQ-012 cmd_err  out  1  one-cycle pulse on any frame error.
REQ-013 err_cnt  out  8  saturating count of cmd_err pulses.

Function
REQ-014 Frame SHALL be 5 bytes in order: SYNC_BYTE, ADDR, DLO, DHI, CSUM; CSUM = ADDR ^ DLO ^ DHI.
REQ-015 States SHALL be S_SYNC, S_ADDR, S_DLO, S_DHI, S_CSUM, S_WRITE.
REQ-016 S_SYNC: rx_rd with rx_data==SYNC_BYTE -> S_ADDR; any other byte discarded silently, no cmd_err.
REQ-017 S_ADDR: on rx_rd, capture byte; bit7=1 -> cmd_err, S_SYNC; else store addr[6:0] -> S_DLO.
REQ-018 S_DLO: on rx_rd, store wdata[7:0] -> S_DHI.
REQ-019 S_DHI: on rx_rd, store wdata[15:8] -> S_CSUM.
REQ-020 S_CSUM: on rx_rd, byte == running XOR -> S_WRITE, reg_wr=1 from next cycle; mismatch -> cmd_err, S_SYNC, no write.
REQ-021 Running XOR SHALL be 8 bits, cleared on entry to S_ADDR, updated with each of ADDR, DLO, DHI.
REQ-022 S_WRITE: reg_wr held 1, reg_addr/reg_wdata unchanged; on edge with reg_ack=1, reg_wr=0 next cycle and state -> S_SYNC.
REQ-023 reg_ack while reg_wr=0 SHALL be ignored.
REQ-024 rx_rd during S_WRITE SHALL drop the byte and pulse cmd_err (overrun); write still completes.
REQ-025 Timeout counter SHALL clear on every accepted byte and on entry to S_ADDR; counts in S_ADDR..S_CSUM only.
REQ-026 Counter reaching TIMEOUT_CLKS-1 with no rx_rd SHALL give cmd_err and S_SYNC on that edge; rx_rd on the same edge wins (byte accepted, no timeout).
REQ-027 No timeout SHALL apply in S_SYNC or S_WRITE.
REQ-028 A SYNC_BYTE value inside ADDR..CSUM SHALL be treated as ordinary data, not a resync.
REQ-029 cmd_err SHALL be exactly one cycle per error event; at most one event per cycle.
REQ-030 err_cnt SHALL increment on each cmd_err and hold at 255.
REQ-031 Latency: reg_wr SHALL assert the cycle after the rx_rd carrying a correct CSUM.

Reset
REQ-032 rst_n=0 SHALL force immediately: state S_SYNC, reg_wr=0, reg_addr=0, reg_wdata=0, busy=0, cmd_err=0, err_cnt=0, XOR and timeout counter 0.
REQ-033 Reset mid-frame or mid-write SHALL abandon the frame; no write after release.
REQ-034 First rx_rd accepted SHALL be on the first rising edge with rst_n=1.

Verification
REQ-035 Bytes A5,12,34,56,70 -> reg_wr=1 next cycle, reg_addr=7'h12, reg_wdata=16'h5634; with reg_ack after 3 cycles -> reg_wr low after the ack cycle, busy=0.
REQ-036 Bytes A5,12,34,56,71 -> cmd_err one pulse, err_cnt=1, no reg_wr.
REQ-037 Bytes 00,FF,A5,80 -> no cmd_err on 00/FF; cmd_err on 80; state S_SYNC.
REQ-038 A5,12 then silence TIMEOUT_CLKS cycles -> cmd_err, busy=0; subsequent full valid frame writes normally.
REQ-039 Valid frame, reg_ack held 0, extra byte 55 -> cmd_err, reg_wr stays 1 with unchanged addr/data until ack.
REQ-040 300 bad-checksum frames -> err_cnt=255; rst_n pulse low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Parses 5-byte register-write frames (SYNC, ADDR, DLO, DHI, CSUM) from a UART byte stream
// and issues a held write request to a register bank, flagging framing errors.
module uart_cmd_parser #(
    parameter int          TIMEOUT_CLKS = 8680,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rd,
    input  logic [7:0]  rx_data,
    output logic        reg_wr,
    output logic [6:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic        reg_ack,
    output logic        busy,
    output logic        cmd_err,
    output logic [7:0]  err_cnt
);
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_ADDR  = 3'd1,
        S_DLO   = 3'd2,
        S_DHI   = 3'd3,
        S_CSUM  = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t         state_q, state_d;
    logic [6:0]     addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [7:0]     csum_q, csum_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           reg_wr_q, busy_q, cmd_err_q;
    logic           err_s;

    // Next-state, field capture, checksum and timeout decisions
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        err_s   = 1'b0;
        case (state_q)
            S_SYNC: begin
                tmo_d = '0;
                if (rx_rd && (rx_data == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                    csum_d  = 8'h00;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_ADDR, S_DLO, S_DHI, S_CSUM: begin
                // An arriving byte always beats an expiring timeout on the same edge
                if (rx_rd) begin
                    tmo_d = '0;
                    case (state_q)
                        S_ADDR: begin
                            if (rx_data[7]) begin
                                err_s   = 1'b1;
                                state_d = S_SYNC;
                            end else begin
                                addr_d  = rx_data[6:0];
                                csum_d  = csum_step(csum_q, rx_data);
                                state_d = S_DLO;
                            end
                        end
                        S_DLO: begin
                            wdata_d[7:0] = rx_data;
                            csum_d       = csum_step(csum_q, rx_data);
                            state_d      = S_DHI;
                        end
                        S_DHI: begin
                            wdata_d[15:8] = rx_data;
                            csum_d        = csum_step(csum_q, rx_data);
                            state_d       = S_CSUM;
                        end
                        S_CSUM: begin
                            if (rx_data == csum_q) begin
                                state_d = S_WRITE;
                            end else begin
                                err_s   = 1'b1;
                                state_d = S_SYNC;
                            end
                        end
                        default: state_d = S_SYNC;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    err_s   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_SYNC;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: begin
                tmo_d = '0;
                err_s = rx_rd;
                if (reg_ack) begin
                    state_d = S_SYNC;
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (err_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SYNC;
            addr_q    <= 7'd0;
            wdata_q   <= 16'd0;
            csum_q    <= 8'd0;
            tmo_q     <= '0;
            err_cnt_q <= 8'd0;
            reg_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
            reg_wr_q  <= (state_d == S_WRITE);
            busy_q    <= (state_d != S_SYNC);
            cmd_err_q <= err_s;
        end
    end

    assign reg_wr    = reg_wr_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = busy_q;
    assign cmd_err   = cmd_err_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus randomized frames
// judged by a frame-level reference (checksum arithmetic, gap lengths, saturating count).
module tb_uart_cmd_parser;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_rd = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        reg_ack = 1'b0;
    logic        reg_wr;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        busy;
    logic        cmd_err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int err_tot = 0;
    int wr_tot = 0;
    int exp_cnt = 0;

    uart_cmd_parser #(.TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rd(rx_rd), .rx_data(rx_data),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .busy(busy), .cmd_err(cmd_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: counts cycles with cmd_err / reg_wr high, sampled mid-cycle
    always begin
        @(posedge clk);
        #2;
        if (cmd_err) err_tot = err_tot + 1;
        if (reg_wr) wr_tot = wr_tot + 1;
    end

    function automatic int sat_add(input int c, input int n);
        return (c + n > 255) ? 255 : c + n;
    endfunction

    // Caller is at a negedge; byte is sampled on the next posedge
    task automatic send_byte(input logic [7:0] b);
        rx_rd = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({reg_wr, reg_addr, reg_wdata, busy, cmd_err, err_cnt} !== 34'd0)
            $display("FAIL reset_hold: got %h want 0", {reg_wr, reg_addr, reg_wdata, busy, cmd_err, err_cnt});
        else n_pass++;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        n_checks++;
        if ({reg_wr, busy, cmd_err, err_cnt} !== 11'd0)
            $display("FAIL reset_release: got %h want 0", {reg_wr, busy, cmd_err, err_cnt});
        else n_pass++;
    endtask

    task automatic test_valid_frame();
        int eb;
        reg_ack = 1'b1;
        idle(3);
        reg_ack = 1'b0;
        n_checks++;
        if ({reg_wr, busy} !== 2'b00) $display("FAIL idle_ack: got %b want 00", {reg_wr, busy});
        else n_pass++;
        eb = err_tot;
        send_byte(8'hA5);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_sync: got %b want 1", busy);
        else n_pass++;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        n_checks++;
        if (reg_wr !== 1'b0) $display("FAIL early_wr: got %b want 0", reg_wr);
        else n_pass++;
        send_byte(8'h70);
        n_checks++;
        if (reg_wr !== 1'b1) $display("FAIL wr_latency: got %b want 1", reg_wr);
        else n_pass++;
        n_checks++;
        if (reg_addr !== 7'h12) $display("FAIL wr_addr: got %h want 12", reg_addr);
        else n_pass++;
        n_checks++;
        if (reg_wdata !== 16'h5634) $display("FAIL wr_data: got %h want 5634", reg_wdata);
        else n_pass++;
        idle(3);
        n_checks++;
        if (reg_wr !== 1'b1) $display("FAIL wr_hold: got %b want 1", reg_wr);
        else n_pass++;
        ack_pulse();
        n_checks++;
        if ({reg_wr, busy} !== 2'b00) $display("FAIL wr_ack_done: got %b want 00", {reg_wr, busy});
        else n_pass++;
        n_checks++;
        if (err_tot - eb !== 0) $display("FAIL valid_no_err: got %0d want 0", err_tot - eb);
        else n_pass++;
    endtask

    task automatic test_bad_csum();
        int eb, wb;
        eb = err_tot; wb = wr_tot;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h71);
        idle(2);
        exp_cnt = sat_add(exp_cnt, 1);
        n_checks++;
        if (err_tot - eb !== 1) $display("FAIL csum_err_pulse: got %0d want 1", err_tot - eb);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 8'd1) $display("FAIL csum_err_cnt: got %0d want 1", err_cnt);
        else n_pass++;
        n_checks++;
        if (wr_tot - wb !== 0) $display("FAIL csum_no_wr: got %0d want 0", wr_tot - wb);
        else n_pass++;
    endtask

    task automatic test_garbage();
        int eb;
        eb = err_tot;
        send_byte(8'h00); send_byte(8'hFF);
        n_checks++;
        if ({busy, 8'(err_tot - eb)} !== 9'd0) $display("FAIL garbage_silent: got %0d/%0d want 0/0", busy, err_tot - eb);
        else n_pass++;
        send_byte(8'hA5); send_byte(8'h80);
        exp_cnt = sat_add(exp_cnt, 1);
        n_checks++;
        if (err_tot - eb !== 1) $display("FAIL addr_bit7_err: got %0d want 1", err_tot - eb);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL addr_bit7_idle: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 8'(exp_cnt)) $display("FAIL garbage_cnt: got %0d want %0d", err_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int eb, wb;
        eb = err_tot;
        send_byte(8'hA5); send_byte(8'h12);
        idle(TMO - 1);
        n_checks++;
        if ({busy, 8'(err_tot - eb)} !== 9'h100) $display("FAIL tmo_early: got busy=%b errs=%0d want 1/0", busy, err_tot - eb);
        else n_pass++;
        idle(1);
        exp_cnt = sat_add(exp_cnt, 1);
        n_checks++;
        if ({busy, 8'(err_tot - eb)} !== 9'h001) $display("FAIL tmo_fire: got busy=%b errs=%0d want 0/1", busy, err_tot - eb);
        else n_pass++;
        // A byte on the very edge the counter would expire is accepted
        eb = err_tot; wb = wr_tot;
        send_byte(8'hA5); send_byte(8'h12);
        idle(TMO - 1);
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h70);
        n_checks++;
        if ({reg_wr, 8'(err_tot - eb)} !== 9'h100) $display("FAIL tmo_edge_wins: got wr=%b errs=%0d want 1/0", reg_wr, err_tot - eb);
        else n_pass++;
        ack_pulse();
        n_checks++;
        if (err_cnt !== 8'(exp_cnt)) $display("FAIL tmo_cnt: got %0d want %0d", err_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int eb;
        send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h3C ^ 8'hA5 ^ 8'h01);
        eb = err_tot;
        idle(2);
        send_byte(8'h55);
        exp_cnt = sat_add(exp_cnt, 1);
        n_checks++;
        if (err_tot - eb !== 1) $display("FAIL overrun_err: got %0d want 1", err_tot - eb);
        else n_pass++;
        n_checks++;
        if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, 7'h3C, 16'h01A5})
            $display("FAIL overrun_hold: got %b/%h/%h want 1/3c/01a5", reg_wr, reg_addr, reg_wdata);
        else n_pass++;
        idle(1);
        ack_pulse();
        n_checks++;
        if ({reg_wr, busy} !== 2'b00) $display("FAIL overrun_done: got %b want 00", {reg_wr, busy});
        else n_pass++;
    endtask

    task automatic test_random(input int n);
        logic [7:0] a, lo, hi, cs, g, sh;
        int kind, eb, wb, exp_errs;
        bit exp_write;
        for (int f = 0; f < n; f++) begin
            kind = int'($urandom_range(0, 9));
            a = 8'($urandom_range(0, 127));
            if (kind < 2) a[7] = 1'b1;
            lo = 8'($urandom);
            if ($urandom_range(0, 3) == 0) lo = 8'hA5;
            hi = 8'($urandom);
            cs = a ^ lo ^ hi;
            sh = 8'h01;
            sh = sh << $urandom_range(0, 7);
            if (kind == 2 || kind == 3) cs = cs ^ sh;
            eb = err_tot; wb = wr_tot;
            exp_errs = 0; exp_write = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
                idle(int'($urandom_range(0, 3)));
            end
            send_byte(8'hA5);
            idle(($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3)));
            send_byte(a);
            if (kind < 2) begin
                exp_errs = 1;
            end else if (kind == 4) begin
                idle(TMO);
                exp_errs = 1;
            end else begin
                idle(($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3)));
                send_byte(lo);
                idle(int'($urandom_range(0, 3)));
                send_byte(hi);
                idle(($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3)));
                send_byte(cs);
                if (kind < 4) exp_errs = 1;
                else exp_write = 1'b1;
            end
            if (exp_write) begin
                n_checks++;
                if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, a[6:0], hi, lo})
                    $display("FAIL rnd_write[%0d]: got %b/%h/%h want 1/%h/%h", f, reg_wr, reg_addr, reg_wdata, a[6:0], {hi, lo});
                else n_pass++;
                idle(int'($urandom_range(0, 3)));
                ack_pulse();
                n_checks++;
                if ({reg_wr, busy} !== 2'b00) $display("FAIL rnd_ack[%0d]: got %b want 00", f, {reg_wr, busy});
                else n_pass++;
            end else begin
                n_checks++;
                if (wr_tot - wb !== 0) $display("FAIL rnd_no_wr[%0d]: got %0d want 0", f, wr_tot - wb);
                else n_pass++;
            end
            exp_cnt = sat_add(exp_cnt, exp_errs);
            n_checks++;
            if (err_tot - eb !== exp_errs) $display("FAIL rnd_errs[%0d]: got %0d want %0d", f, err_tot - eb, exp_errs);
            else n_pass++;
            n_checks++;
            if (err_cnt !== 8'(exp_cnt)) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", f, err_cnt, exp_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_saturation_and_reset();
        int eb, wb;
        eb = err_tot;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h06);
        end
        exp_cnt = sat_add(exp_cnt, 300);
        n_checks++;
        if (err_tot - eb !== 300) $display("FAIL sat_pulses: got %0d want 300", err_tot - eb);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 8'(exp_cnt)) $display("FAIL sat_cnt: got %0d want %0d", err_cnt, exp_cnt);
        else n_pass++;
        // Reset mid-frame: outputs clear without a clock, frame tail is then ignored
        send_byte(8'hA5); send_byte(8'h12);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_checks++;
        if ({reg_wr, reg_addr, reg_wdata, busy, cmd_err, err_cnt} !== 34'd0)
            $display("FAIL midframe_rst: got %h want 0", {reg_wr, reg_addr, reg_wdata, busy, cmd_err, err_cnt});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        eb = err_tot; wb = wr_tot;
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h70);
        idle(3);
        n_checks++;
        if ({8'(err_tot - eb), 8'(wr_tot - wb), busy} !== 17'd0)
            $display("FAIL midframe_abandon: got errs=%0d wrs=%0d busy=%b want 0", err_tot - eb, wr_tot - wb, busy);
        else n_pass++;
        // Reset mid-write
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h70);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({reg_wr, reg_addr, reg_wdata, busy, cmd_err, err_cnt} !== 34'd0)
            $display("FAIL midwrite_rst: got %h want 0", {reg_wr, reg_addr, reg_wdata, busy, cmd_err, err_cnt});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wb = wr_tot;
        idle(5);
        n_checks++;
        if (wr_tot - wb !== 0) $display("FAIL midwrite_abandon: got %0d want 0", wr_tot - wb);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_csum();
        test_garbage();
        test_timeout();
        test_overrun();
        test_random(40);
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
